// File: rtl/lb_pkg.sv
// Shared constants for the localbus master: FSM state encodings,
// the pad word used when a slave stays silent, and default widths.
package lb_pkg;

   localparam int LB_DATA_WIDTH = 32;
   localparam int LB_ADDR_WIDTH = 24;
   localparam int LB_NPIPE      = 16;
   localparam int LB_RSP_DEPTH  = 32;
   localparam int LB_LEN_WIDTH  = 8;

   typedef logic [2:0] lb_state_t;

   localparam lb_state_t ST_IDLE  = 3'd0;
   localparam lb_state_t ST_WRITE = 3'd1;
   localparam lb_state_t ST_READ  = 3'd2;
   localparam lb_state_t ST_DRAIN = 3'd3;
   localparam lb_state_t ST_PAD   = 3'd4;

   // Word substituted for beats a slave never answered.
   localparam logic [31:0] LB_DEADBEEF = 32'hdeadbeef;

endpackage

// File: rtl/lb_rsp_fifo.sv
// First-word-fall-through response FIFO. Output data is forced to zero
// while empty so nothing stale leaks onto the host stream.
module lb_rsp_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           rdata_o,
   output logic                       empty_o,
   output logic                       full_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [PW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign count_o = count_q;
   assign do_pop  = pop_i && !empty_o;
   // A push into a full FIFO is only taken when a word leaves the same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = empty_o ? '0 : mem[rd_ptr_q];

   // Storage write; contents need no reset because count gates visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data_i;
   end

   // Pointer and occupancy bookkeeping (depth is a power of two, pointers wrap).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PW+1)'(1);
            2'b01:   count_q <= count_q - (PW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/lb_master.sv
// Localbus master: turns host write/read-burst commands into localbus
// strobes and read delay lines, and returns read data through a
// credit-limited response FIFO.
module lb_master
   import lb_pkg::*;
#(
   parameter int DATA_WIDTH = LB_DATA_WIDTH,
   parameter int ADDR_WIDTH = LB_ADDR_WIDTH,
   parameter int NPIPE      = LB_NPIPE,
   parameter int RSP_DEPTH  = LB_RSP_DEPTH,
   parameter int LEN_WIDTH  = LB_LEN_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_write,
   input  logic [ADDR_WIDTH-1:0]       cmd_addr,
   input  logic [DATA_WIDTH-1:0]       cmd_wdata,
   input  logic [LEN_WIDTH-1:0]        cmd_len,
   output logic                        rsp_valid,
   input  logic                        rsp_ready,
   output logic [DATA_WIDTH-1:0]       rsp_data,
   output logic                        rsp_last,
   output logic                        lb_wren,
   output logic [ADDR_WIDTH-1:0]       lb_waddr,
   output logic [DATA_WIDTH-1:0]       lb_wdata,
   output logic [NPIPE*ADDR_WIDTH-1:0] lb_raddr16,
   output logic [NPIPE-1:0]            lb_rden16,
   output logic [NPIPE-1:0]            lb_rdenlast16,
   input  logic [DATA_WIDTH-1:0]       lb_rdata,
   input  logic                        lb_rvalid,
   input  logic                        lb_rvalidlast,
   output logic                        busy,
   output logic                        err_noresp
);

   localparam int CNT_W = LEN_WIDTH + 1;
   localparam int FCW   = $clog2(RSP_DEPTH) + 1;

   lb_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]      rcv_cnt_q, rcv_cnt_d;
   logic                  err_q, err_d;

   logic [ADDR_WIDTH-1:0] raddr_q [NPIPE];
   logic [NPIPE-1:0]      rden_q, rdlast_q;

   logic                  issue, issue_last, rcv_last, can_issue;
   logic [CNT_W-1:0]      inflight;
   logic [31:0]           credit_sum;
   logic                  push, push_last;
   logic [DATA_WIDTH-1:0] push_word;
   logic [FCW-1:0]        fifo_count;
   logic                  fifo_full, fifo_empty;
   logic [DATA_WIDTH:0]   fifo_rdata;

   assign cmd_ready  = (state_q == ST_IDLE);
   assign busy       = (state_q != ST_IDLE);
   assign err_noresp = err_q;
   assign lb_wren    = (state_q == ST_WRITE);
   assign lb_waddr   = lb_wren ? addr_q  : '0;
   assign lb_wdata   = lb_wren ? wdata_q : '0;

   assign issue_last = (issue_cnt_q == CNT_W'(len_q));
   assign rcv_last   = (rcv_cnt_q == CNT_W'(len_q));
   // Reserve a FIFO slot for every beat still in the slave pipeline.
   assign inflight   = issue_cnt_q - rcv_cnt_q;
   assign credit_sum = 32'(fifo_count) + 32'(inflight);
   assign can_issue  = (credit_sum < 32'(RSP_DEPTH));

   // Next-state logic for the command FSM, beat issue and response capture.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      len_d       = len_q;
      issue_cnt_d = issue_cnt_q;
      rcv_cnt_d   = rcv_cnt_q;
      err_d       = err_q;
      issue       = 1'b0;
      push        = 1'b0;
      push_last   = 1'b0;
      push_word   = '0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               addr_d = cmd_addr;
               if (cmd_write) begin
                  wdata_d = cmd_wdata;
                  state_d = ST_WRITE;
               end else begin
                  len_d       = cmd_len;
                  issue_cnt_d = '0;
                  rcv_cnt_d   = '0;
                  state_d     = ST_READ;
               end
            end
         end
         ST_WRITE: state_d = ST_IDLE;
         ST_READ, ST_DRAIN: begin
            // Last flag comes from our own beat count; the slave's flag is only a cross-check.
            if (lb_rvalid) begin
               push      = 1'b1;
               push_word = lb_rdata;
               push_last = rcv_last;
               rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
               if (lb_rvalidlast != rcv_last) err_d = 1'b1;
            end
            if (state_q == ST_READ) begin
               if (can_issue) begin
                  issue       = 1'b1;
                  addr_d      = addr_q + ADDR_WIDTH'(1);
                  issue_cnt_d = issue_cnt_q + CNT_W'(1);
                  if (issue_last) state_d = ST_DRAIN;
               end
            end else if (rcv_cnt_d == CNT_W'(len_q) + CNT_W'(1)) begin
               state_d = ST_IDLE;
            end else if (rden_q == '0) begin
               // Pipeline flushed without all beats returning: slave is silent.
               state_d = ST_PAD;
               err_d   = 1'b1;
            end
         end
         ST_PAD: begin
            if (!fifo_full) begin
               push      = 1'b1;
               push_word = DATA_WIDTH'(LB_DEADBEEF);
               push_last = rcv_last;
               rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
               if (rcv_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM and command/counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         rcv_cnt_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         rcv_cnt_q   <= rcv_cnt_d;
         err_q       <= err_d;
      end
   end

   // Stage 0 of the delay lines: the beat issued this cycle, or zeros.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         raddr_q[0] <= '0;
         rden_q     <= '0;
         rdlast_q   <= '0;
      end else begin
         raddr_q[0] <= issue ? addr_q : '0;
         rden_q     <= {rden_q[NPIPE-2:0], issue};
         rdlast_q   <= {rdlast_q[NPIPE-2:0], issue && issue_last};
      end
   end

   generate
      for (genvar gi = 1; gi < NPIPE; gi++) begin : g_raddr_shift
         // Address delay line stage gi follows stage gi-1 every cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) raddr_q[gi] <= '0;
            else        raddr_q[gi] <= raddr_q[gi-1];
         end
      end
      for (genvar gi = 0; gi < NPIPE; gi++) begin : g_raddr_pack
         assign lb_raddr16[gi*ADDR_WIDTH +: ADDR_WIDTH] = raddr_q[gi];
      end
   endgenerate

   assign lb_rden16     = rden_q;
   assign lb_rdenlast16 = rdlast_q;

   lb_rsp_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_data_i ({push_word, push_last}),
      .pop_i       (rsp_ready),
      .rdata_o     (fifo_rdata),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .count_o     (fifo_count)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_data  = fifo_rdata[DATA_WIDTH:1];
   assign rsp_last  = fifo_rdata[0];

endmodule

// File: tb/tb_lb_master.sv
// Directed bench for lb_master with a small behavioural slave
// (READDELAY=1) and a 4-deep response FIFO to exercise credit stalls.
module tb_lb_master;

   localparam int DW = 32;
   localparam int AW = 24;
   localparam int NP = 16;
   localparam int RD = 4;
   localparam int LW = 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0]     cmd_addr;
   logic [DW-1:0]     cmd_wdata;
   logic [LW-1:0]     cmd_len;
   logic              rsp_valid, rsp_ready, rsp_last;
   logic [DW-1:0]     rsp_data;
   logic              lb_wren;
   logic [AW-1:0]     lb_waddr;
   logic [DW-1:0]     lb_wdata;
   logic [NP*AW-1:0]  lb_raddr16;
   logic [NP-1:0]     lb_rden16, lb_rdenlast16;
   logic [DW-1:0]     lb_rdata;
   logic              lb_rvalid, lb_rvalidlast;
   logic              busy, err_noresp;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lb_master #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NPIPE(NP), .RSP_DEPTH(RD), .LEN_WIDTH(LW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
      .lb_wren(lb_wren), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
      .lb_raddr16(lb_raddr16), .lb_rden16(lb_rden16), .lb_rdenlast16(lb_rdenlast16),
      .lb_rdata(lb_rdata), .lb_rvalid(lb_rvalid), .lb_rvalidlast(lb_rvalidlast),
      .busy(busy), .err_noresp(err_noresp)
   );

   // ---------------- behavioural slave, READDELAY = 1 ----------------
   logic          silent = 1'b0;
   logic [DW-1:0] dacsel_q;
   logic [AW-1:0] s_addr;

   function automatic logic [DW-1:0] slave_word(input logic [AW-1:0] a, input logic [DW-1:0] dac);
      if (a == 9)              return 32'h7fff0000;
      if (a == 25)             return dac;
      if (a >= 32 && a < 64)   return 32'h10000000 + 32'(a);
      if (a < 64)              return 32'h0;
      return 32'hdeadbeef;
   endfunction

   assign s_addr        = lb_raddr16[2*AW-1:AW];
   assign lb_rvalid     = !silent && lb_rden16[1];
   assign lb_rvalidlast = lb_rvalid && lb_rdenlast16[1];
   assign lb_rdata      = lb_rvalid ? slave_word(s_addr, dacsel_q) : '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)                            dacsel_q <= '0;
      else if (lb_wren && lb_waddr == 25)    dacsel_q <= lb_wdata;
   end

   // ---------------- monitors ----------------
   logic [DW:0] rxq[$];
   int          issued = 0;
   logic        ovf_seen = 1'b0;

   always @(negedge clk) begin
      if (rsp_valid && rsp_ready) rxq.push_back({rsp_data, rsp_last});
      if (lb_rden16[0]) issued++;
      if (lb_rvalid && dut.u_rsp_fifo.count_o >= 3'(RD) && !(rsp_valid && rsp_ready))
         ovf_seen = 1'b1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [LW-1:0] l);
      int   n;
      logic seen;
      @(posedge clk); #1;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_len = l;
      n = 0; seen = 1'b0;
      while (!seen && n < 200) begin
         @(negedge clk); seen = cmd_ready;
         @(posedge clk); #1;
         n++;
      end
      cmd_valid = 1'b0;
      check("cmd_accept", 64'(seen), 64'd1);
      $display("[TB] cmd write=%0d addr=%0d wdata=%0h len=%0d", w, a, d, l);
   endtask

   task automatic wait_idle(input int maxc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < maxc);
      check("idle_timeout", 64'(busy), 64'd0);
   endtask

   // ---------------- directed sequence ----------------
   int base;
   int ibase;

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_len = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",      64'(busy),       64'd0);
      check("rst_wren",      64'(lb_wren),    64'd0);
      check("rst_rden16",    64'(lb_rden16),  64'd0);
      check("rst_rsp_valid", 64'(rsp_valid),  64'd0);
      check("rst_err",       64'(err_noresp), 64'd0);
      check("rst_cmd_ready", 64'(cmd_ready),  64'd1);
      rst_n = 1'b1;

      // single write: one strobe, the cycle after the handshake
      send_cmd(1'b1, 24'd25, 32'd3, 8'd0);
      @(negedge clk);
      check("wr_wren",  64'(lb_wren),  64'd1);
      check("wr_waddr", 64'(lb_waddr), 64'd25);
      check("wr_wdata", 64'(lb_wdata), 64'd3);
      @(negedge clk);
      check("wr_wren_drop", 64'(lb_wren), 64'd0);
      check("wr_idle",      64'(busy),    64'd0);

      // dacsel readback
      rsp_ready = 1'b1;
      base = rxq.size();
      send_cmd(1'b0, 24'd25, 32'd0, 8'd0);
      wait_idle(100);
      repeat (3) @(negedge clk);
      check("rb_count", 64'(rxq.size() - base), 64'd1);
      if (rxq.size() > base) check("rb_word", 64'(rxq[base]), {31'd0, 32'd3, 1'b1});

      // burst read addr 9 len 3
      base = rxq.size();
      send_cmd(1'b0, 24'd9, 32'd0, 8'd3);
      wait_idle(100);
      repeat (3) @(negedge clk);
      check("b4_count", 64'(rxq.size() - base), 64'd4);
      if (rxq.size() >= base + 4) begin
         check("b4_w0", 64'(rxq[base+0]), {31'd0, 32'd2147418112, 1'b0});
         check("b4_w1", 64'(rxq[base+1]), {31'd0, 32'd0, 1'b0});
         check("b4_w2", 64'(rxq[base+2]), {31'd0, 32'd0, 1'b0});
         check("b4_w3", 64'(rxq[base+3]), {31'd0, 32'd0, 1'b1});
      end
      check("b4_drained", 64'(rsp_valid), 64'd0);

      // unmapped address: slave default word, no error
      base = rxq.size();
      send_cmd(1'b0, 24'd100, 32'd0, 8'd0);
      wait_idle(100);
      repeat (3) @(negedge clk);
      check("um_count", 64'(rxq.size() - base), 64'd1);
      if (rxq.size() > base) check("um_word", 64'(rxq[base]), {31'd0, 32'hdeadbeef, 1'b1});
      check("um_err", 64'(err_noresp), 64'd0);

      // credit stall: 4-deep FIFO, host stalled, 16-beat burst
      rsp_ready = 1'b0;
      base  = rxq.size();
      ibase = issued;
      send_cmd(1'b0, 24'd32, 32'd0, 8'd15);
      repeat (50) @(negedge clk);
      check("cr_issued_stall", 64'(issued - ibase), 64'd4);
      check("cr_rsp_valid",    64'(rsp_valid),      64'd1);
      check("cr_busy",         64'(busy),           64'd1);
      rsp_ready = 1'b1;
      wait_idle(400);
      repeat (3) @(negedge clk);
      check("cr_issued_total", 64'(issued - ibase),     64'd16);
      check("cr_count",        64'(rxq.size() - base),  64'd16);
      if (rxq.size() >= base + 16) begin
         for (int i = 0; i < 16; i++)
            check($sformatf("cr_w%0d", i), 64'(rxq[base+i]),
                  {31'd0, 32'h10000020 + 32'(i), (i == 15) ? 1'b1 : 1'b0});
      end
      check("cr_no_overflow", 64'(ovf_seen), 64'd0);
      check("cr_err", 64'(err_noresp), 64'd0);

      // silent slave: pad words and sticky error
      silent = 1'b1;
      base = rxq.size();
      send_cmd(1'b0, 24'd50, 32'd0, 8'd2);
      wait_idle(200);
      repeat (3) @(negedge clk);
      check("pad_count", 64'(rxq.size() - base), 64'd3);
      if (rxq.size() >= base + 3) begin
         check("pad_w0", 64'(rxq[base+0]), {31'd0, 32'hdeadbeef, 1'b0});
         check("pad_w1", 64'(rxq[base+1]), {31'd0, 32'hdeadbeef, 1'b0});
         check("pad_w2", 64'(rxq[base+2]), {31'd0, 32'hdeadbeef, 1'b1});
      end
      check("pad_err",  64'(err_noresp), 64'd1);
      check("pad_idle", 64'(cmd_ready),  64'd1);
      silent = 1'b0;

      // reset in the middle of a burst
      rsp_ready = 1'b0;
      send_cmd(1'b0, 24'd32, 32'd0, 8'd15);
      repeat (3) @(negedge clk);
      check("mr_pre_busy", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mr_busy",      64'(busy),              64'd0);
      check("mr_rden16",    64'(lb_rden16),         64'd0);
      check("mr_raddr16",   64'(lb_raddr16 == '0),  64'd1);
      check("mr_rsp_valid", 64'(rsp_valid),         64'd0);
      check("mr_rsp_data",  64'(rsp_data),          64'd0);
      check("mr_err",       64'(err_noresp),        64'd0);
      check("mr_wren",      64'(lb_wren),           64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      base = rxq.size();
      send_cmd(1'b0, 24'd40, 32'd0, 8'd1);
      wait_idle(100);
      repeat (3) @(negedge clk);
      check("mr_count", 64'(rxq.size() - base), 64'd2);
      if (rxq.size() >= base + 2) begin
         check("mr_w0", 64'(rxq[base+0]), {31'd0, 32'h10000028, 1'b0});
         check("mr_w1", 64'(rxq[base+1]), {31'd0, 32'h10000029, 1'b1});
      end
      check("mr_err_after", 64'(err_noresp), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lb_master.md
Name: lb_master

Overview:
- Upstream driver of the local bus that feeds every register-file interface (DSP regs, acquisition regs, etc.).
- Accepts host commands on a valid/ready stream: single-word writes and incrementing-address read bursts.
- Drives the localbus write strobes and the 16-deep read-address/read-enable delay lines.
- Collects slave read data (rdata/rvalid/rvalidlast) into a credit-controlled response FIFO streamed back to the host.

Parameters:
DATA_WIDTH, 32, localbus data width
ADDR_WIDTH, 24, localbus word-address width
NPIPE, 16, depth of raddr16/rden16/rdenlast16 delay lines; slave READDELAY+1 must be < NPIPE
RSP_DEPTH, 32, response FIFO depth in words (power of 2)
LEN_WIDTH, 8, burst length field; burst = cmd_len+1 beats

Ports:
clk  in  1  localbus clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_write  in  1  1=write, 0=read burst
cmd_addr  in  ADDR_WIDTH  start word address
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
cmd_len  in  LEN_WIDTH  read beats minus 1 (ignored for writes)
rsp_valid  out  1  response word valid
rsp_ready  in  1  host accepts response
rsp_data  out  DATA_WIDTH  read data
rsp_last  out  1  final word of burst
lb_wren  out  1  write strobe
lb_waddr  out  ADDR_WIDTH  write address
lb_wdata  out  DATA_WIDTH  write data
lb_raddr16  out  NPIPE*ADDR_WIDTH  read-address delay line, stage k in bits [(k+1)*AW-1:k*AW]
lb_rden16  out  NPIPE  read-enable delay line
lb_rdenlast16  out  NPIPE  last-beat delay line
lb_rdata  in  DATA_WIDTH  OR of slave read data
lb_rvalid  in  1  read data valid
lb_rvalidlast  in  1  read data is last beat
busy  out  1  FSM not IDLE
err_noresp  out  1  sticky: a burst ended with missing beats

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; all lb_* outputs 0; delay lines 0; FIFO empty; rsp_valid=0; err_noresp=0; counters 0.
- Delay lines shift every cycle: stage k+1 <= stage k. Stage 0 loaded with the issued beat (rden=1, raddr, rdenlast) or with 0s when no issue.
- cmd_ready=1 only in IDLE.
- FSM states:
  - IDLE: on a write handshake -> WRITE. On a read handshake -> latch addr/len, issue_cnt=0, rcv_cnt=0 -> READ.
  - WRITE: lb_wren=1 for exactly one cycle, the cycle after the handshake, with lb_waddr/lb_wdata = latched values; -> IDLE. Back-to-back writes therefore give one strobe per 2 cycles.
  - READ: issue one beat per cycle while credit allows; address increments by 1 per beat (wraps modulo 2^ADDR_WIDTH); rdenlast=1 on beat cmd_len. After the last issue -> DRAIN.
  - DRAIN: wait until rcv_cnt==cmd_len+1 -> IDLE. If lb_rden16 becomes all-zero first (pipeline flushed, slave silent) -> PAD.
  - PAD: push 32'hdeadbeef, one per cycle when the FIFO has space, until the burst count is met; final pad has rsp_last=1. Set err_noresp on entry; -> IDLE.
- Credit: a beat is issued only if fifo_count + inflight < RSP_DEPTH. inflight = issued − received for the current burst. The FIFO can never overflow; an lb_rvalid arriving with the FIFO full is impossible by construction and is asserted in the bench.
- Response capture:
  - On lb_rvalid, push {lb_rdata, rsp_last}. rsp_last = (rcv_cnt==cmd_len), not lb_rvalidlast; lb_rvalidlast is used only as a consistency check (mismatch sets err_noresp).
  - lb_rvalid outside READ/DRAIN is ignored.
- FIFO: first-word fall-through; rsp_valid = !empty. Simultaneous push and pop when full is allowed only when a pop occurs.
- Latency: first read word is pushed READDELAY+2 cycles after issue.
- err_noresp clears only on reset.

Decomposition:
- Package lb_pkg: state enum (IDLE, WRITE, READ, DRAIN, PAD), DEADBEEF constant, default widths.
- Sub-module lb_rsp_fifo: synchronous FWFT FIFO, DATA_WIDTH+1 wide, RSP_DEPTH deep, exposes count. Same clk/rst_n.

Test Plan:
- Write cmd addr=25 data=3 -> lb_wren high 1 cycle, lb_waddr=25, lb_wdata=3; dacsel slave reads back 3.
- Read addr=9 len=3, slave READDELAY=1, rsp_ready=1 -> 4 words 2147418112, 0, 0, 0; rsp_last only on 4th; busy drops after the last push.
- RSP_DEPTH=4, read len=15, rsp_ready=0 for 50 cycles -> exactly 4 beats issued, no overflow; after release all 16 words arrive in address order.
- Read of unmapped addr=100 -> deadbeef from the slave default; err_noresp stays 0.
- Read with no slave responding, len=2 -> 3 deadbeef pad words, last on 3rd, err_noresp=1, FSM returns to IDLE.
- rst_n asserted mid-burst -> all outputs 0 immediately; the next command after release completes normally.
